event_pulse_stretcher: RTL and testbench

- Output-side counterpart to the switch debouncers.
- Debouncers reject short glitches on mechanical inputs. This block expands short internal events (clip detect, buffer overrun, effect toggle) into fixed-length, human-visible LED pulses with a guaranteed off-gap.
- Events arriving while a pulse is in progress are counted, up to a limit, and replayed as separate blinks.
- Sits between effect/status logic and the board LED pins.

---
 rtl/audio_fx_pkg.sv | 18 +
 rtl/event_pulse_stretcher_pulse_timer.sv | 34 +++
 rtl/event_pulse_stretcher.sv | 121 ++++++++++++
 tb/tb_event_pulse_stretcher.sv | 134 +++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effects status/indicator logic.
//   state_t       : pulse stretcher FSM states
//   C_*_DEF       : default timing and sizing for a 10 MHz system clock
package audio_fx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int C_HOLD_DEF    = 100_000;  // 10 ms LED on-time
  localparam int C_GAP_DEF     = 50_000;   // 5 ms forced off-time
  localparam int C_PEND_MAX_DEF = 7;
  localparam int C_CNT_W_DEF   = 20;
  localparam int C_PEND_W_DEF  = 3;

endpackage

// File: rtl/event_pulse_stretcher_pulse_timer.sv
// pulse_timer: loadable up-counter with a terminal-count flag, shared by the
// hold and gap phases of the pulse stretcher.
//   clk, rst_n : clock, async active-low reset
//   start      : reload the count to zero on the next edge
//   limit      : phase length in clocks (>= 1); done flags count == limit-1
//   done       : combinational terminal-count flag
module pulse_timer #(
  parameter int c_cnt_w = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [c_cnt_w-1:0] limit,
  output logic               done
);

  localparam logic [c_cnt_w-1:0] ONE = c_cnt_w'(1);

  logic [c_cnt_w-1:0] count;
  logic [c_cnt_w-1:0] last;

  assign last = limit - ONE;
  assign done = (count == last);

  // Stops at the terminal value instead of wrapping. The limit input can
  // switch to a shorter phase while the count is parked (e.g. in IDLE), so
  // the hold-off uses < rather than != to stay bounded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           count <= '0;
    else if (start)       count <= '0;
    else if (count < last) count <= count + ONE;
  end

endmodule

// File: rtl/event_pulse_stretcher.sv
// event_pulse_stretcher: turns short internal events into fixed-length LED
// blinks with a guaranteed off-gap. Events that arrive during a blink are
// queued (saturating) and replayed as separate blinks.
//   clk, rst_n : clock, async active-low reset
//   i_event    : event request; each rising edge is one event
//   i_clear    : drop queued events and clear the overflow flag
//   o_led      : stretched LED drive
//   o_busy     : FSM not idle (rises together with o_led)
//   o_pending  : queued events not yet displayed
//   o_overflow : sticky, an event was dropped on a full queue
module event_pulse_stretcher
  import audio_fx_pkg::*;
#(
  parameter int c_hold_limit  = C_HOLD_DEF,
  parameter int c_gap_limit   = C_GAP_DEF,
  parameter int c_pending_max = C_PEND_MAX_DEF,
  parameter int c_cnt_w       = C_CNT_W_DEF,
  parameter int c_pend_w      = C_PEND_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_event,
  input  logic                i_clear,
  output logic                o_led,
  output logic                o_busy,
  output logic [c_pend_w-1:0] o_pending,
  output logic                o_overflow
);

  localparam logic [c_pend_w-1:0] PEND_ONE = c_pend_w'(1);
  localparam logic [c_pend_w-1:0] PEND_MAX = c_pend_w'(c_pending_max);

  state_t              state, state_nxt;
  logic                r_event_d;
  logic                ev_edge, act_edge;
  logic                queue_ev;
  logic [c_pend_w-1:0] pend_nxt, pend_eff;
  logic                ovf_nxt;
  logic                tmr_start, tmr_done;
  logic [c_cnt_w-1:0]  tmr_limit;

  assign ev_edge   = i_event & ~r_event_d;
  // While a blink is running, a clear wins over a simultaneous edge and
  // also hides the queue from the gap-exit decision.
  assign act_edge  = ev_edge & ~i_clear;
  assign pend_eff  = i_clear ? '0 : o_pending;
  assign tmr_limit = (state == GAP) ? c_cnt_w'(c_gap_limit) : c_cnt_w'(c_hold_limit);

  pulse_timer #(.c_cnt_w(c_cnt_w)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tmr_start),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    pend_nxt  = o_pending;
    ovf_nxt   = o_overflow;
    tmr_start = 1'b0;
    queue_ev  = 1'b0;
    case (state)
      IDLE: begin
        if (ev_edge) begin
          state_nxt = HOLD;
          tmr_start = 1'b1;
        end
      end
      HOLD: begin
        queue_ev = act_edge;
        if (tmr_done) begin
          state_nxt = GAP;
          tmr_start = 1'b1;
        end
      end
      GAP: begin
        if (tmr_done) begin
          if (pend_eff != '0 || act_edge) begin
            state_nxt = HOLD;
            tmr_start = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
          // An edge on the exit cycle replaces the dequeued event.
          if (pend_eff != '0 && !act_edge) pend_nxt = o_pending - PEND_ONE;
        end else begin
          queue_ev = act_edge;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (queue_ev) begin
      if (o_pending < PEND_MAX) pend_nxt = o_pending + PEND_ONE;
      else                      ovf_nxt  = 1'b1;
    end
    if (i_clear) begin
      pend_nxt = '0;
      ovf_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_event_d  <= 1'b1;  // a level already high at reset release is not an event
      o_led      <= 1'b0;
      o_busy     <= 1'b0;
      o_pending  <= '0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      r_event_d  <= i_event;
      o_led      <= (state_nxt == HOLD);
      o_busy     <= (state_nxt != IDLE);
      o_pending  <= pend_nxt;
      o_overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_event_pulse_stretcher.sv
// Directed bench for event_pulse_stretcher with hold=4, gap=2, pending max=3.
// Each scenario is a set of per-tick strings: character i is the input driven
// before rising edge i, or the output expected just after that edge.
module tb_event_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_event;
  logic       i_clear;
  logic       o_led;
  logic       o_busy;
  logic [1:0] o_pending;
  logic       o_overflow;

  int n_chk  = 0;
  int n_fail = 0;

  event_pulse_stretcher #(
    .c_hold_limit  (4),
    .c_gap_limit   (2),
    .c_pending_max (3),
    .c_cnt_w       (3),
    .c_pend_w      (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_event    (i_event),
    .i_clear    (i_clear),
    .o_led      (o_led),
    .o_busy     (o_busy),
    .o_pending  (o_pending),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dig(input string s, input int i);
    logic [7:0] c;
    c = s.getc(i);
    return 32'(c) - 32'd48;
  endfunction

  task automatic chk(input string tag, input int tick, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s tick %0d: observed %0d expected %0d", tag, tick, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int tick, input logic [31:0] led,
                           input logic [31:0] busy, input logic [31:0] pend,
                           input logic [31:0] ovf);
    chk({tag, ".led"},  tick, 32'(o_led),      led);
    chk({tag, ".busy"}, tick, 32'(o_busy),     busy);
    chk({tag, ".pend"}, tick, 32'(o_pending),  pend);
    chk({tag, ".ovf"},  tick, 32'(o_overflow), ovf);
  endtask

  task automatic run(input string tag, input string ev, input string clr,
                     input string led, input string busy, input string pend,
                     input string ovf);
    for (int i = 0; i < ev.len(); i++) begin
      i_event = dig(ev, i)[0];
      i_clear = dig(clr, i)[0];
      @(posedge clk);
      #1;
      check_all(tag, i, dig(led, i), dig(busy, i), dig(pend, i), dig(ovf, i));
    end
    i_event = 1'b0;
    i_clear = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_event = 1'b0;
    i_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single one-cycle event
    run("single", "100000000000", "000000000000",
        "111100000000", "111111000000", "000000000000", "000000000000");

    // three separated events: queued and replayed as three blinks
    run("three", "10101000000000000000", "00000000000000000000",
        "11110011110011110000", "11111111111111111100",
        "00112211111100000000", "00000000000000000000");

    // queue saturates at 3, one event dropped, five blinks total
    run("sat", "10101001010100000000000000000000",
        "00000000000000000000000000000000",
        "11110011110011110011110011110000",
        "11111111111111111111111111111100",
        "00112212233322222211111100000000",
        "00000000000111111111111111111111");

    // clear during the second blink; an edge alongside clear is discarded
    run("clear", "1010100101000000", "0000000011000000",
        "1111001111000000", "1111111111110000",
        "0011221200000000", "1111111100000000");

    // reset mid-HOLD with two events queued
    run("prerst", "10101001", "00000000",
        "11110011", "11111111", "00112212", "00000000");
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run("postrst", "00000000", "00000000",
        "00000000", "00000000", "00000000", "00000000");

    // level held through reset release, later edge, then edge on gap exit
    i_event = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run("level", "11110100000100000000", "00000000000000000000",
        "00000111100111100000", "00000111111111111000",
        "00000000000000000000", "00000000000000000000");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
